// File: rtl/ula_seq_param.sv
// Registered ALU with a start/busy/done handshake. Logic and arithmetic ops finish
// in one cycle; LSL/LSR shift one bit per clock with the amount saturated at WIDTH.
module ula_seq_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       op_sel,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] resultado_out,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned MSB   = WIDTH - 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   res_q;
    logic               c_q;
    logic               v_q;
    logic               z_q;
    logic               n_q;
    logic [WIDTH-1:0]   sh_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               dir_q;

    logic [WIDTH:0]     sum_c;
    logic [WIDTH:0]     diff_c;
    logic [CNT_W-1:0]   amt_c;
    logic               is_shift_c;
    logic [WIDTH-1:0]   alu_r_c;
    logic               alu_c_c;
    logic               alu_v_c;
    logic [WIDTH-1:0]   sh_d;
    logic               sh_out_c;
    logic [WIDTH-1:0]   res_d;
    logic               c_d;
    logic               v_d;
    logic               z_d;
    logic               n_d;

    // Single-cycle datapath; zero-distance shifts pass A through unchanged.
    always_comb begin
        sum_c      = {1'b0, a_in} + {1'b0, b_in};
        diff_c     = {1'b0, a_in} - {1'b0, b_in};
        amt_c      = (b_in >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(b_in);
        is_shift_c = op_sel[2] & op_sel[1];
        alu_r_c    = a_in;
        alu_c_c    = 1'b0;
        alu_v_c    = 1'b0;
        case (op_sel)
            OP_AND:  alu_r_c = a_in & b_in;
            OP_OR:   alu_r_c = a_in | b_in;
            OP_NOT:  alu_r_c = ~a_in;
            OP_NAND: alu_r_c = ~(a_in & b_in);
            OP_ADD: begin
                alu_r_c = sum_c[WIDTH-1:0];
                alu_c_c = sum_c[WIDTH];
                alu_v_c = (a_in[MSB] == b_in[MSB]) & (sum_c[MSB] != a_in[MSB]);
            end
            OP_SUB: begin
                alu_r_c = diff_c[WIDTH-1:0];
                alu_c_c = ~diff_c[WIDTH];
                alu_v_c = (a_in[MSB] != b_in[MSB]) & (diff_c[MSB] != a_in[MSB]);
            end
            default: alu_r_c = a_in;
        endcase
    end

    // One-position shift step; dir_q=1 is LSR.
    always_comb begin
        if (dir_q) begin
            sh_d     = {1'b0, sh_q[WIDTH-1:1]};
            sh_out_c = sh_q[0];
        end else begin
            sh_d     = {sh_q[WIDTH-2:0], 1'b0};
            sh_out_c = sh_q[MSB];
        end
    end

    always_comb begin
        if (state_q == SHIFT) begin
            res_d = sh_d;
            c_d   = sh_out_c;
            v_d   = 1'b0;
        end else begin
            res_d = alu_r_c;
            c_d   = alu_c_c;
            v_d   = alu_v_c;
        end
        z_d = (res_d == '0);
        n_d = res_d[MSB];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        if (is_shift_c && (amt_c != '0)) begin
                            sh_q    <= a_in;
                            cnt_q   <= amt_c;
                            dir_q   <= op_sel[0];
                            busy_q  <= 1'b1;
                            state_q <= SHIFT;
                        end else begin
                            res_q  <= res_d;
                            c_q    <= c_d;
                            v_q    <= v_d;
                            z_q    <= z_d;
                            n_q    <= n_d;
                            done_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Last step: publish the shifted value and the final bit out.
                    if (cnt_q == CNT_W'(1)) begin
                        res_q   <= res_d;
                        c_q     <= c_d;
                        v_q     <= v_d;
                        z_q     <= z_d;
                        n_q     <= n_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign resultado_out = res_q;
    assign flag_c        = c_q;
    assign flag_v        = v_q;
    assign flag_z        = z_q;
    assign flag_n        = n_q;

endmodule

// File: tb/tb_ula_seq_param.sv
// Bench for ula_seq_param (WIDTH=8): directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_ula_seq_param;

    logic       clk;
    logic       rst;
    logic       start_in;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [2:0] op_sel;
    logic       busy_out;
    logic       done_out;
    logic [7:0] resultado_out;
    logic       flag_c;
    logic       flag_v;
    logic       flag_z;
    logic       flag_n;

    int n_cmp;
    int n_bad;

    ula_seq_param #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_in      (start_in),
        .a_in          (a_in),
        .b_in          (b_in),
        .op_sel        (op_sel),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .resultado_out (resultado_out),
        .flag_c        (flag_c),
        .flag_v        (flag_v),
        .flag_z        (flag_z),
        .flag_n        (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on unsigned/signed values.
    function automatic void model(input int op, input int a, input int b,
                                  output int r, output int c, output int v, output int lat);
        int n;
        int sa;
        int sb;
        int t;
        n   = (b > 8) ? 8 : b;
        sa  = (a >= 128) ? a - 256 : a;
        sb  = (b >= 128) ? b - 256 : b;
        c   = 0;
        v   = 0;
        lat = 0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = 255 - a;
            3: r = 255 - (a & b);
            4: begin
                t = a + b;
                r = t % 256;
                c = t / 256;
                v = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0;
            end
            5: begin
                r = (a - b + 256) % 256;
                c = (a >= b) ? 1 : 0;
                v = ((sa - sb) > 127 || (sa - sb) < -128) ? 1 : 0;
            end
            6: begin
                t   = a * (1 << n);
                r   = t % 256;
                c   = (n > 0) ? (t / 256) % 2 : 0;
                lat = n;
            end
            default: begin
                r   = a / (1 << n);
                c   = (n > 0) ? (a / (1 << (n - 1))) % 2 : 0;
                lat = n;
            end
        endcase
    endfunction

    // Issues one op, then waits (bounded) for done; operands are scrambled after acceptance.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int busy_cnt, output bit got_done);
        @(negedge clk);
        op_sel   = op;
        a_in     = a;
        b_in     = b;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        a_in     = 8'($urandom);
        b_in     = 8'($urandom);
        op_sel   = 3'($urandom);
        busy_cnt = 0;
        got_done = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (done_out) begin
                got_done = 1'b1;
            end else begin
                if (busy_out) busy_cnt++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset;
        logic [12:0] outs;
        bit          pulsed;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_in = 1'b1;
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            op_sel   = 3'($urandom);
            @(posedge clk);
            #1;
            outs = {busy_out, done_out, resultado_out, flag_c, flag_v, flag_z, flag_n};
            n_cmp++;
            if (outs !== 13'd0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got %h expected 0", i, outs);
            end
        end
        @(negedge clk);
        start_in = 1'b0;
        rst      = 1'b0;
        pulsed   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (done_out || busy_out) pulsed = 1'b1;
        end
        outs = {busy_out, done_out, resultado_out, flag_c, flag_v, flag_z, flag_n};
        n_cmp++;
        if (pulsed !== 1'b0 || outs !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_idle: got pulse=%0b outs=%h expected pulse=0 outs=0", pulsed, outs);
        end
    endtask

    task automatic test_arith;
        logic [2:0] ops [5] = '{3'b100, 3'b100, 3'b101, 3'b101, 3'b101};
        logic [7:0] as  [5] = '{8'h7F, 8'hFF, 8'h05, 8'h00, 8'h80};
        logic [7:0] bs  [5] = '{8'h01, 8'h01, 8'h05, 8'h01, 8'h01};
        logic [7:0] er  [5] = '{8'h80, 8'h00, 8'h00, 8'hFF, 8'h7F};
        logic [3:0] ef  [5] = '{4'b0101, 4'b1010, 4'b1010, 4'b0001, 4'b1100};
        int         bc;
        bit         gd;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], bc, gd);
            n_cmp++;
            if (!gd || bc !== 0 || resultado_out !== er[i]
                || {flag_c, flag_v, flag_z, flag_n} !== ef[i]) begin
                n_bad++;
                $display("FAIL arith[%0d]: got done=%0b busy=%0d r=%h cvzn=%b expected done=1 busy=0 r=%h cvzn=%b",
                         i, gd, bc, resultado_out, {flag_c, flag_v, flag_z, flag_n}, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_shift;
        logic [2:0] ops [3] = '{3'b110, 3'b111, 3'b110};
        logic [7:0] as  [3] = '{8'hA0, 8'hF0, 8'h5A};
        logic [7:0] bs  [3] = '{8'd1, 8'd200, 8'd0};
        logic [7:0] er  [3] = '{8'h40, 8'h00, 8'h5A};
        logic [3:0] ef  [3] = '{4'b1000, 4'b1010, 4'b0000};
        int         el  [3] = '{1, 8, 0};
        int         bc;
        bit         gd;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], bc, gd);
            n_cmp++;
            if (!gd || bc !== el[i] || busy_out !== 1'b0 || resultado_out !== er[i]
                || {flag_c, flag_v, flag_z, flag_n} !== ef[i]) begin
                n_bad++;
                $display("FAIL shift[%0d]: got done=%0b busy=%0d r=%h cvzn=%b expected done=1 busy=%0d r=%h cvzn=%b",
                         i, gd, bc, resultado_out, {flag_c, flag_v, flag_z, flag_n}, el[i], er[i], ef[i]);
            end
        end
    endtask

    task automatic test_ignore_busy;
        int bc;
        bit gd;
        bit extra;
        @(negedge clk);
        op_sel   = 3'b111;
        a_in     = 8'h80;
        b_in     = 8'd4;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        bc = 0;
        gd = 1'b0;
        for (int i = 0; i < 20 && !gd; i++) begin
            if (done_out) begin
                gd = 1'b1;
            end else begin
                if (busy_out) bc++;
                if (i < 2) begin
                    @(negedge clk);
                    start_in = 1'b1;
                    op_sel   = 3'b100;
                    a_in     = 8'($urandom);
                    b_in     = 8'($urandom);
                end
                @(posedge clk);
                #1;
                start_in = 1'b0;
            end
        end
        n_cmp++;
        if (!gd || bc !== 4 || resultado_out !== 8'h08
            || {flag_c, flag_v, flag_z, flag_n} !== 4'b0000) begin
            n_bad++;
            $display("FAIL ignore_busy: got done=%0b busy=%0d r=%h cvzn=%b expected done=1 busy=4 r=08 cvzn=0000",
                     gd, bc, resultado_out, {flag_c, flag_v, flag_z, flag_n});
        end
        extra = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done_out || busy_out) extra = 1'b1;
        end
        n_cmp++;
        if (extra !== 1'b0 || resultado_out !== 8'h08) begin
            n_bad++;
            $display("FAIL not_queued: got activity=%0b r=%h expected activity=0 r=08", extra, resultado_out);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        op_sel   = 3'b110;
        a_in     = 8'h01;
        b_in     = 8'd2;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        op_sel = 3'b100;
        a_in   = 8'h03;
        b_in   = 8'h04;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy_out !== 1'b1 || done_out !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_busy: got busy=%0b done=%0b expected busy=1 done=0", busy_out, done_out);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (done_out !== 1'b1 || busy_out !== 1'b0 || resultado_out !== 8'h04 || flag_c !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_first: got done=%0b busy=%0b r=%h c=%0b expected done=1 busy=0 r=04 c=0",
                     done_out, busy_out, resultado_out, flag_c);
        end
        @(posedge clk);
        #1;
        start_in = 1'b0;
        n_cmp++;
        if (done_out !== 1'b1 || busy_out !== 1'b0 || resultado_out !== 8'h07) begin
            n_bad++;
            $display("FAIL b2b_second: got done=%0b busy=%0b r=%h expected done=1 busy=0 r=07",
                     done_out, busy_out, resultado_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        logic [12:0] outs;
        bit          pulsed;
        int          bc;
        bit          gd;
        @(negedge clk);
        op_sel   = 3'b110;
        a_in     = 8'h01;
        b_in     = 8'd6;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        outs = {busy_out, done_out, resultado_out, flag_c, flag_v, flag_z, flag_n};
        n_cmp++;
        if (outs !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_mid_immediate: got %h expected 0", outs);
        end
        @(negedge clk);
        rst    = 1'b0;
        pulsed = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done_out || busy_out) pulsed = 1'b1;
        end
        n_cmp++;
        if (pulsed !== 1'b0 || resultado_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_no_done: got pulse=%0b r=%h expected pulse=0 r=00", pulsed, resultado_out);
        end
        run_op(3'b100, 8'h12, 8'h34, bc, gd);
        n_cmp++;
        if (!gd || resultado_out !== 8'h46 || {flag_c, flag_v, flag_z, flag_n} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_mid_recover: got done=%0b r=%h cvzn=%b expected done=1 r=46 cvzn=0000",
                     gd, resultado_out, {flag_c, flag_v, flag_z, flag_n});
        end
    endtask

    task automatic test_random;
        int          r;
        int          c;
        int          v;
        int          lat;
        int          bc;
        bit          gd;
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [11:0] got;
        logic [11:0] exp;
        for (int k = 0; k < 2000; k++) begin
            op = 3'($urandom);
            a  = 8'($urandom);
            b  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            model(int'(op), int'(a), int'(b), r, c, v, lat);
            run_op(op, a, b, bc, gd);
            got = {resultado_out, flag_c, flag_v, flag_z, flag_n};
            exp = {8'(r), 1'(c), 1'(v), (r == 0) ? 1'b1 : 1'b0, 1'(r / 128)};
            n_cmp++;
            if (!gd || got !== exp || bc !== lat) begin
                n_bad++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: got done=%0b r=%h cvzn=%b busy=%0d expected r=%h cvzn=%b busy=%0d",
                         k, op, a, b, gd, got[11:4], got[3:0], bc, exp[11:4], exp[3:0], lat);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (done_out !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_pulse[%0d]: got done=%0b one cycle after done expected 0", k, done_out);
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        start_in = 1'b0;
        a_in     = '0;
        b_in     = '0;
        op_sel   = '0;
        test_reset();
        test_arith();
        test_shift();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
